projectile_pool: RTL

- Parametrised pool of N projectiles, replacing the single hard-wired allied and enemy ball of the current game core.
- Accepts spawn requests from the ship or enemy logic, moves every live projectile once per frame tick, and retires projectiles that leave the screen or hit the target box.
- Counts hits and exports flattened position and alive vectors for the screen renderer.
- The same module is instantiated once for allied shots (DIR_UP=1) and once for enemy shots (DIR_UP=0).

---
 rtl/projectile_pool_pkg.sv | 20 ++
 rtl/projectile_pool_hit_box_check.sv | 44 ++++
 rtl/projectile_pool.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/projectile_pool_pkg.sv
// Shared game definitions: screen geometry, pool FSM states
// and the flattened-bus packing used by the screen renderer.
package projectile_pool_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int COORD_W  = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_UPDATE,
      ST_DONE
   } state_t;

   // Slot i occupies bits [COORD_W*i +: COORD_W] of a flat bus.
   function automatic int flat_lsb(input int i);
      return i * COORD_W;
   endfunction

endpackage

// File: rtl/projectile_pool_hit_box_check.sv
// Expanded AABB test: a point of given radius against a box.
// Shared by the ship, enemy and projectile collision logic.
module hit_box_check
   import projectile_pool_pkg::*;
#(
   parameter int RADIUS = 3
) (
   input  logic [COORD_W-1:0] px,
   input  logic [COORD_W-1:0] py,
   input  logic [COORD_W-1:0] bx,
   input  logic [COORD_W-1:0] by,
   input  logic [COORD_W-1:0] bw,
   input  logic [COORD_W-1:0] bh,
   output logic               hit
);

   // Two spare bits keep box end plus radius from overflowing.
   localparam int W = COORD_W + 2;

   logic [W-1:0] px_e;
   logic [W-1:0] py_e;
   logic [W-1:0] bx_e;
   logic [W-1:0] by_e;
   logic [W-1:0] bw_e;
   logic [W-1:0] bh_e;
   logic         hit_x;
   logic         hit_y;

   assign px_e = {2'b00, px};
   assign py_e = {2'b00, py};
   assign bx_e = {2'b00, bx};
   assign by_e = {2'b00, by};
   assign bw_e = {2'b00, bw};
   assign bh_e = {2'b00, bh};

   // p <= b + size - 1 + r is written as p < b + size + r
   // so a zero-size box never underflows.
   assign hit_x = (px_e + W'(RADIUS) >= bx_e)
               && (px_e < bx_e + bw_e + W'(RADIUS));
   assign hit_y = (py_e + W'(RADIUS) >= by_e)
               && (py_e < by_e + bh_e + W'(RADIUS));
   assign hit   = hit_x && hit_y;

endmodule

// File: rtl/projectile_pool.sv
// Pool of N projectiles: spawns into the lowest free slot, moves
// every live slot once per frame tick, retires on exit or on hit.
module projectile_pool
   import projectile_pool_pkg::*;
#(
   parameter int N      = 4,
   parameter int SPEED  = 4,
   parameter int RADIUS = 3,
   parameter int DIR_UP = 1,
   parameter int HIT_CW = 8
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 pausa,
   input  logic                 tick,
   input  logic                 spawn_req,
   input  logic [9:0]           spawn_x,
   input  logic [9:0]           spawn_y,
   output logic                 spawn_ack,
   output logic                 spawn_drop,
   input  logic [9:0]           tgt_x,
   input  logic [9:0]           tgt_y,
   input  logic [9:0]           tgt_w,
   input  logic [9:0]           tgt_h,
   input  logic                 tgt_alive,
   output logic [10*N-1:0]      x_flat,
   output logic [10*N-1:0]      y_flat,
   output logic [N-1:0]         alive,
   output logic                 full,
   output logic                 busy,
   output logic                 hit,
   output logic [HIT_CW-1:0]    hit_count
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = COORD_W + 1;

   state_t              state;
   state_t              state_nx;
   logic [IW-1:0]       idx;
   logic [COORD_W-1:0]  x_r [N];
   logic [COORD_W-1:0]  y_r [N];
   logic [N-1:0]        alive_r;
   logic                pass_hit;
   logic                ack_r;
   logic                drop_r;
   logic [HIT_CW-1:0]   cnt_r;

   logic                spawn_go;
   logic                free_found;
   logic [IW-1:0]       free_idx;
   logic [CW-1:0]       y_ext;
   logic [CW-1:0]       y_mv;
   logic                retire;
   logic                box_hit;

   // Pass sequencer state register.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Next state: a tick starts a pass, N slot cycles, one DONE.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (tick && !pausa) state_nx = ST_UPDATE;
         ST_UPDATE: if (idx == IW'(N - 1)) state_nx = ST_DONE;
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Lowest-index free slot; scanning downward lets low wins.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!alive_r[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   // A held request is taken once: the ack pulse masks it.
   assign spawn_go = (state == ST_IDLE) && !pausa
                  && spawn_req && !ack_r;

   // Move the current slot and test for screen exit.
   always_comb begin
      y_ext  = {1'b0, y_r[idx]};
      y_mv   = (DIR_UP != 0) ? y_ext - CW'(SPEED)
                             : y_ext + CW'(SPEED);
      retire = (DIR_UP != 0) ? (y_ext < CW'(SPEED))
                             : (y_mv > CW'(SCREEN_H - 1));
   end

   hit_box_check #(
      .RADIUS (RADIUS)
   ) u_hit_box (
      .px  (x_r[idx]),
      .py  (y_mv[COORD_W-1:0]),
      .bx  (tgt_x),
      .by  (tgt_y),
      .bw  (tgt_w),
      .bh  (tgt_h),
      .hit (box_hit)
   );

   // Slot storage, spawn handshake, per-slot update, hit counter.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            x_r[i] <= '0;
            y_r[i] <= '0;
         end
         alive_r  <= '0;
         idx      <= '0;
         pass_hit <= 1'b0;
         ack_r    <= 1'b0;
         drop_r   <= 1'b0;
         cnt_r    <= '0;
      end else begin
         ack_r  <= 1'b0;
         drop_r <= 1'b0;
         if (spawn_go) begin
            if (free_found) begin
               x_r[free_idx]     <= spawn_x;
               y_r[free_idx]     <= spawn_y;
               alive_r[free_idx] <= 1'b1;
               ack_r             <= 1'b1;
            end else begin
               drop_r <= 1'b1;
            end
         end
         if (state == ST_IDLE) begin
            idx      <= '0;
            pass_hit <= 1'b0;
         end
         if (state == ST_UPDATE) begin
            idx <= idx + IW'(1);
            if (alive_r[idx]) begin
               if (retire) begin
                  alive_r[idx] <= 1'b0;
               end else begin
                  y_r[idx] <= y_mv[COORD_W-1:0];
                  if (tgt_alive && box_hit) begin
                     alive_r[idx] <= 1'b0;
                     pass_hit     <= 1'b1;
                     if (cnt_r != {HIT_CW{1'b1}})
                        cnt_r <= cnt_r + HIT_CW'(1);
                  end
               end
            end
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_flat
      assign x_flat[flat_lsb(i) +: COORD_W] = x_r[i];
      assign y_flat[flat_lsb(i) +: COORD_W] = y_r[i];
   end

   assign alive      = alive_r;
   assign full       = &alive_r;
   assign busy       = (state != ST_IDLE);
   assign hit        = (state == ST_DONE) && pass_hit;
   assign hit_count  = cnt_r;
   assign spawn_ack  = ack_r;
   assign spawn_drop = drop_r;

endmodule
